// File: rtl/poly_song_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_song_pkg
//  Description : Shared definitions for the polyphonic song reader: FSM state
//                encoding, ROM word field offset helpers and the lowest-index
//                voice selector.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_song_pkg;

    // Explicitly sized, explicitly valued state encoding.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_WAIT_ROM = 4'd2,
        S_DECODE   = 4'd3,
        S_DISPATCH = 4'd4,
        S_REST     = 4'd5,
        S_NEXT     = 4'd6,
        S_END      = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    // ROM word layout, LSB first: meta, duration, note, advance.
    localparam int c_meta_lsb = 0;

    // The selector works on a fixed-width vector; voice count must not exceed it.
    localparam int c_max_voices = 32;

    function automatic int dur_lsb(input int meta_w);
        return meta_w;
    endfunction

    function automatic int note_lsb(input int meta_w, input int dur_w);
        return meta_w + dur_w;
    endfunction

    function automatic int adv_bit(input int meta_w, input int dur_w, input int note_w);
        return meta_w + dur_w + note_w;
    endfunction

    // Isolates the lowest set bit (two's-complement trick): v & -v.
    function automatic logic [c_max_voices-1:0] lowest_onehot(input logic [c_max_voices-1:0] v);
        return v & (~v + {{(c_max_voices-1){1'b0}}, 1'b1});
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_song_reader_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : beat_counter
//  Description : Loadable down-counter that measures rest lengths in beats.
//                A load takes priority over counting; counting only happens on
//                an enabled beat and saturates at zero.
//  Ports       : clk      - system clock
//                reset    - synchronous active-high reset
//                load_i   - load value_i into the counter
//                value_i  - load value (beats)
//                beat_i   - one-cycle beat pulse
//                en_i     - count enable (gates beat_i)
//                zero_o   - counter value after this cycle's update is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module beat_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             beat_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && beat_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looks at the next value so the owner can leave on the very beat that
    // empties the counter rather than one cycle later.
    assign zero_o = (cnt_d == '0);

endmodule
`default_nettype wire

// File: rtl/poly_song_reader.sv
`default_nettype none
// ============================================================================
//  Module      : poly_song_reader
//  Description : Walks a song held in an external synchronous ROM and hands
//                note events to the lowest-index free player voice. Rest
//                entries are timed on the beat counter. Supports pause, loop
//                mode and a clean restart when the song select changes.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                play              - 1 run / 0 pause
//                loop_en           - restart at address 0 instead of finishing
//                song              - song select
//                beat              - one-cycle beat pulse
//                player_available  - per-voice ready
//                rom_addr          - {song_q, addr_q}
//                rom_dout          - ROM word {advance, note, duration, meta}
//                note/duration/meta- fields of the last dispatch (registered)
//                new_note          - one-hot dispatch strobe
//                song_done         - one-cycle pulse at song end
//                busy              - not IDLE and not DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_song_reader
    import poly_song_pkg::*;
#(
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int META_W     = 3,
    parameter int ADDR_W     = 7,
    parameter int SONG_W     = 2,
    parameter int NUM_VOICES = 3,
    parameter int ROM_LAT    = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              play,
    input  logic                              loop_en,
    input  logic [SONG_W-1:0]                 song,
    input  logic                              beat,
    input  logic [NUM_VOICES-1:0]             player_available,
    output logic [SONG_W+ADDR_W-1:0]          rom_addr,
    input  logic [NOTE_W+DUR_W+META_W:0]      rom_dout,
    output logic [NOTE_W-1:0]                 note,
    output logic [DUR_W-1:0]                  duration,
    output logic [META_W-1:0]                 meta,
    output logic [NUM_VOICES-1:0]             new_note,
    output logic                              song_done,
    output logic                              busy
);

    localparam int c_word_w   = 1 + NOTE_W + DUR_W + META_W;
    localparam int c_dur_lsb  = dur_lsb(META_W);
    localparam int c_note_lsb = note_lsb(META_W, DUR_W);
    localparam int c_adv_bit  = adv_bit(META_W, DUR_W, NOTE_W);
    localparam int c_lat_w    = $clog2(ROM_LAT + 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q,  addr_d;
    logic [SONG_W-1:0]       song_q,  song_d;
    logic [c_word_w-1:0]     word_q,  word_d;
    logic [c_lat_w-1:0]      lat_q,   lat_d;
    logic [NOTE_W-1:0]       note_q,  note_d;
    logic [DUR_W-1:0]        dur_q,   dur_d;
    logic [META_W-1:0]       meta_q,  meta_d;

    logic                    w_busy;
    logic                    w_song_chg;
    logic [NUM_VOICES-1:0]   w_grant;
    logic [NUM_VOICES-1:0]   w_new_note;
    logic                    w_song_done;
    logic                    w_tmr_load;
    logic [DUR_W-1:0]        w_tmr_value;
    logic                    w_tmr_en;
    logic                    w_tmr_zero;

    logic                    w_adv;
    logic [NOTE_W-1:0]       w_note;
    logic [DUR_W-1:0]        w_dur;
    logic [META_W-1:0]       w_meta;

    assign w_adv  = word_q[c_adv_bit];
    assign w_note = word_q[c_note_lsb +: NOTE_W];
    assign w_dur  = word_q[c_dur_lsb  +: DUR_W];
    assign w_meta = word_q[c_meta_lsb +: META_W];

    assign w_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    // A song change outranks every other event in the same cycle.
    assign w_song_chg = w_busy && play && (song != song_q);
    assign w_grant    = NUM_VOICES'(lowest_onehot(c_max_voices'(player_available)));
    assign w_tmr_en   = play && (state_q == S_REST) && !w_song_chg;

    beat_counter #(
        .WIDTH (DUR_W)
    ) u_beat_counter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (w_tmr_load),
        .value_i (w_tmr_value),
        .beat_i  (beat),
        .en_i    (w_tmr_en),
        .zero_o  (w_tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        song_d      = song_q;
        word_d      = word_q;
        lat_d       = lat_q;
        note_d      = note_q;
        dur_d       = dur_q;
        meta_d      = meta_q;
        w_new_note  = '0;
        w_song_done = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;

        if (w_song_chg) begin
            song_d     = song;
            addr_d     = '0;
            w_tmr_load = 1'b1;
            state_d    = S_FETCH;
        end else if (!play) begin
            // Paused: everything holds, except DONE which waits for play to fall.
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    song_d  = song;
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    lat_d   = c_lat_w'(ROM_LAT);
                    state_d = S_WAIT_ROM;
                end
                S_WAIT_ROM: begin
                    if (lat_q <= c_lat_w'(1)) begin
                        lat_d   = '0;
                        word_d  = rom_dout;
                        state_d = S_DECODE;
                    end else begin
                        lat_d = lat_q - 1'b1;
                    end
                end
                S_DECODE: begin
                    if (word_q == '0) begin
                        state_d = S_END;
                    end else if (w_adv) begin
                        if (w_dur == '0) begin
                            state_d = S_NEXT;
                        end else begin
                            w_tmr_load  = 1'b1;
                            w_tmr_value = w_dur;
                            state_d     = S_REST;
                        end
                    end else begin
                        state_d = S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (|player_available) begin
                        w_new_note = w_grant;
                        note_d     = w_note;
                        dur_d      = w_dur;
                        meta_d     = w_meta;
                        state_d    = S_NEXT;
                    end
                end
                S_REST: begin
                    if (w_tmr_zero) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    // The last word routes to END so the address never wraps.
                    if (&addr_q) begin
                        state_d = S_END;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_END: begin
                    if (loop_en) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        w_song_done = 1'b1;
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            song_q  <= '0;
            word_q  <= '0;
            lat_q   <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            meta_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            song_q  <= song_d;
            word_q  <= word_d;
            lat_q   <= lat_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            meta_q  <= meta_d;
        end
    end

    assign rom_addr  = {song_q, addr_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign meta      = meta_q;
    assign new_note  = w_new_note;
    assign song_done = w_song_done;
    assign busy      = w_busy;

endmodule
`default_nettype wire
